// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read/write/claim/debug bundle for the scoreboarded regfile.
// slave is the register file, master is the pipeline driving it.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DBG_W  = 16
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;

  logic              wr_en_0;
  logic [ADDR_W-1:0] wr_addr_0;
  logic [DATA_W-1:0] wr_data_0;
  logic              wr_en_1;
  logic [ADDR_W-1:0] wr_addr_1;
  logic [DATA_W-1:0] wr_data_1;

  logic              link_en;
  logic [DATA_W-1:0] link_data;

  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic              claim_ok;
  logic [ADDR_W:0]   pend_cnt;

  logic [ADDR_W-1:0] dbg_addr;
  logic [DBG_W-1:0]  dbg_data;

  modport master (
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    input  rd_busy_a, rd_busy_b,
    output wr_en_0, wr_addr_0, wr_data_0,
    output wr_en_1, wr_addr_1, wr_data_1,
    output link_en, link_data,
    output claim_en, claim_addr,
    input  claim_ok, pend_cnt,
    output dbg_addr,
    input  dbg_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    output rd_busy_a, rd_busy_b,
    input  wr_en_0, wr_addr_0, wr_data_0,
    input  wr_en_1, wr_addr_1, wr_data_1,
    input  link_en, link_data,
    input  claim_en, claim_addr,
    output claim_ok, pend_cnt,
    input  dbg_addr,
    output dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file + link write + pending-result scoreboard.
// Optional same-cycle read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DBG_W    = 16,
  parameter int LINK_REG = 31,
  parameter int ZERO_R0  = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [ADDR_W:0]   cnt;

  logic we_l;
  logic we_0;
  logic we_1;
  logic clr_eff;
  logic claim_ok;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign we_l = bus.link_en & ~is_r0(LINK_A);
  assign we_0 = bus.wr_en_0 & ~is_r0(bus.wr_addr_0);
  assign we_1 = bus.wr_en_1 & ~is_r0(bus.wr_addr_1);

  assign claim_ok = bus.claim_en
                  & ~pending[bus.claim_addr]
                  & ~is_r0(bus.claim_addr);

  // port 1 retires the pending result even if its data lost priority
  assign clr_eff = bus.wr_en_1 & pending[bus.wr_addr_1];

  // later assignments win: link > port 0 > port 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (we_1)
        regs[bus.wr_addr_1] <= bus.wr_data_1;
      if (we_0)
        regs[bus.wr_addr_0] <= bus.wr_data_0;
      if (we_l)
        regs[LINK_A] <= bus.link_data;
    end
  end

  always_comb begin
    pending_nxt = pending;
    if (bus.wr_en_1)
      pending_nxt[bus.wr_addr_1] = 1'b0;
    if (claim_ok)
      pending_nxt[bus.claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pending_nxt;
      unique case ({claim_ok, clr_eff})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rbusy [2];

  assign ra[0] = bus.rd_addr_a;
  assign ra[1] = bus.rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[ra[p]];
      rbusy[p] = pending[ra[p]];
`ifdef REGFILE_BYPASS_EN
      if (!rst) begin
        if (we_1 && bus.wr_addr_1 == ra[p])
          rdata[p] = bus.wr_data_1;
        if (we_0 && bus.wr_addr_0 == ra[p])
          rdata[p] = bus.wr_data_0;
        if (we_l && LINK_A == ra[p])
          rdata[p] = bus.link_data;
        if (bus.wr_en_1 && bus.wr_addr_1 == ra[p])
          rbusy[p] = 1'b0;
      end
`endif
      if (is_r0(ra[p])) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  logic [DATA_W-1:0] dbg_word;
  assign dbg_word = regs[bus.dbg_addr];

  assign bus.rd_data_a = rdata[0];
  assign bus.rd_data_b = rdata[1];
  assign bus.rd_busy_a = rbusy[0];
  assign bus.rd_busy_b = rbusy[1];
  assign bus.claim_ok  = claim_ok;
  assign bus.pend_cnt  = cnt;
  assign bus.dbg_data  = dbg_word[DBG_W-1:0];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus reset/scoreboard-fill sequences.
// Expected values are hand computed for the default 32x32 configuration.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .DBG_W(16)) bus ();

  regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .DBG_W(16), .LINK_REG(31), .ZERO_R0(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        le;  logic [31:0] ld;
    logic        ce;  logic [4:0] ca;
    logic [4:0]  ra;  logic [4:0] rb;  logic [4:0] da;
    logic        x_ok;
    logic [31:0] x_pre_b;
    logic [31:0] x_a; logic [31:0] x_b;
    logic        x_ba; logic x_bb;
    logic [5:0]  x_cnt;
    logic [15:0] x_dbg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en_0  = 1'b0;
    bus.wr_en_1  = 1'b0;
    bus.link_en  = 1'b0;
    bus.claim_en = 1'b0;
  endtask

  vec_t v [12];

  initial begin
    v[0]  = '{1,5'd5,32'hDEADBEEF, 0,5'd0,32'h0, 0,32'h0, 0,5'd0,
              5'd5,5'd0,5'd5, 0,32'h0,
              32'hDEADBEEF,32'h0, 0,0, 6'd0,16'hBEEF};
    v[1]  = '{1,5'd31,32'h200, 1,5'd31,32'h300, 1,32'h100, 0,5'd0,
              5'd31,5'd5,5'd31, 0,32'hDEADBEEF,
              32'h100,32'hDEADBEEF, 0,0, 6'd0,16'h0100};
    v[2]  = '{0,5'd0,32'h0, 0,5'd0,32'h0, 0,32'h0, 1,5'd7,
              5'd7,5'd31,5'd7, 1,32'h100,
              32'h0,32'h100, 1,0, 6'd1,16'h0000};
    v[3]  = '{0,5'd0,32'h0, 0,5'd0,32'h0, 0,32'h0, 1,5'd7,
              5'd7,5'd5,5'd5, 0,32'hDEADBEEF,
              32'h0,32'hDEADBEEF, 1,0, 6'd1,16'hBEEF};
    v[4]  = '{0,5'd0,32'h0, 1,5'd7,32'h55, 0,32'h0, 0,5'd0,
              5'd7,5'd31,5'd7, 0,32'h100,
              32'h55,32'h100, 0,0, 6'd0,16'h0055};
    v[5]  = '{1,5'd0,32'h1234, 0,5'd0,32'h0, 0,32'h0, 1,5'd0,
              5'd0,5'd7,5'd0, 0,32'h55,
              32'h0,32'h55, 0,0, 6'd0,16'h0000};
    v[6]  = '{0,5'd0,32'h0, 0,5'd0,32'h0, 0,32'h0, 1,5'd10,
              5'd10,5'd10,5'd10, 1,32'h0,
              32'h0,32'h0, 1,1, 6'd1,16'h0000};
    v[7]  = '{0,5'd0,32'h0, 1,5'd10,32'hAB, 0,32'h0, 1,5'd11,
              5'd10,5'd11,5'd10, 1,32'h0,
              32'hAB,32'h0, 0,1, 6'd1,16'h00AB};
    v[8]  = '{1,5'd11,32'h77, 1,5'd11,32'h88, 0,32'h0, 0,5'd0,
              5'd11,5'd5,5'd11, 0,32'hDEADBEEF,
              32'h77,32'hDEADBEEF, 0,0, 6'd0,16'h0077};
    v[9]  = '{0,5'd0,32'h0, 1,5'd12,32'h99, 0,32'h0, 0,5'd0,
              5'd12,5'd11,5'd12, 0,32'h77,
              32'h99,32'h77, 0,0, 6'd0,16'h0099};
    v[10] = '{1,5'd3,32'hA5, 0,5'd0,32'h0, 0,32'h0, 0,5'd0,
              5'd5,5'd3,5'd3, 0,(BYP ? 32'hA5 : 32'h0),
              32'hDEADBEEF,32'hA5, 0,0, 6'd0,16'h00A5};
    v[11] = '{0,5'd0,32'h0, 0,5'd0,32'h0, 1,32'hCAFE0001, 0,5'd0,
              5'd31,5'd12,5'd31, 0,32'h99,
              32'hCAFE0001,32'h99, 0,0, 6'd0,16'h0001};

    idle();
    bus.wr_addr_0 = '0; bus.wr_data_0 = '0;
    bus.wr_addr_1 = '0; bus.wr_data_1 = '0;
    bus.link_data = '0; bus.claim_addr = '0;
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd7; bus.dbg_addr = 5'd5;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_pend_cnt", 32'(bus.pend_cnt), 32'h0);
    chk("reset_rd_a", bus.rd_data_a, 32'h0);
    chk("reset_busy_b", 32'(bus.rd_busy_b), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.wr_en_0 = v[i].w0e; bus.wr_addr_0 = v[i].w0a;
      bus.wr_data_0 = v[i].w0d;
      bus.wr_en_1 = v[i].w1e; bus.wr_addr_1 = v[i].w1a;
      bus.wr_data_1 = v[i].w1d;
      bus.link_en = v[i].le; bus.link_data = v[i].ld;
      bus.claim_en = v[i].ce; bus.claim_addr = v[i].ca;
      bus.rd_addr_a = v[i].ra; bus.rd_addr_b = v[i].rb;
      bus.dbg_addr = v[i].da;
      #1;
      chk($sformatf("v%0d_claim_ok", i), 32'(bus.claim_ok), 32'(v[i].x_ok));
      chk($sformatf("v%0d_pre_rd_b", i), bus.rd_data_b, v[i].x_pre_b);
      @(posedge clk);
      #1 idle();
      #1;
      chk($sformatf("v%0d_rd_a", i), bus.rd_data_a, v[i].x_a);
      chk($sformatf("v%0d_rd_b", i), bus.rd_data_b, v[i].x_b);
      chk($sformatf("v%0d_busy_a", i), 32'(bus.rd_busy_a), 32'(v[i].x_ba));
      chk($sformatf("v%0d_busy_b", i), 32'(bus.rd_busy_b), 32'(v[i].x_bb));
      chk($sformatf("v%0d_pend_cnt", i), 32'(bus.pend_cnt), 32'(v[i].x_cnt));
      chk($sformatf("v%0d_dbg", i), 32'(bus.dbg_data), 32'(v[i].x_dbg));
    end

    // fill the scoreboard: r1..r31 claimable, r0 never
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      bus.claim_en = 1'b1; bus.claim_addr = 5'(r);
      #1 chk($sformatf("fill_ok_r%0d", r), 32'(bus.claim_ok), 32'h1);
    end
    @(negedge clk);
    idle();
    chk("fill_pend_cnt", 32'(bus.pend_cnt), 32'd31);
    bus.claim_en = 1'b1; bus.claim_addr = 5'd0;
    #1 chk("fill_claim_r0", 32'(bus.claim_ok), 32'h0);
    bus.claim_addr = 5'd20;
    #1 chk("fill_claim_dup", 32'(bus.claim_ok), 32'h0);
    bus.claim_en = 1'b0;
    bus.wr_en_1 = 1'b1; bus.wr_addr_1 = 5'd20; bus.wr_data_1 = 32'h2020;
    @(posedge clk);
    #1 idle();
    #1 chk("fill_clear_cnt", 32'(bus.pend_cnt), 32'd30);

    // asynchronous reset with a full scoreboard
    @(negedge clk);
    rst = 1'b1;
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd1; bus.dbg_addr = 5'd5;
    #1;
    chk("rst1_pend_cnt", 32'(bus.pend_cnt), 32'h0);
    chk("rst1_rd_a", bus.rd_data_a, 32'h0);
    chk("rst1_busy_b", 32'(bus.rd_busy_b), 32'h0);
    chk("rst1_dbg", 32'(bus.dbg_data), 32'h0);
    @(negedge clk) rst = 1'b0;

    // write r5, claim r1..r3, then reset mid-burst
    bus.wr_en_0 = 1'b1; bus.wr_addr_0 = 5'd5; bus.wr_data_0 = 32'h11;
    for (int r = 1; r <= 3; r++) begin
      bus.claim_en = 1'b1; bus.claim_addr = 5'(r);
      @(negedge clk);
      bus.wr_en_0 = 1'b0;
    end
    chk("burst_pend_cnt", 32'(bus.pend_cnt), 32'd3);
    chk("burst_rd_r5", bus.rd_data_a, 32'h11);
    bus.claim_addr = 5'd4;
    bus.wr_en_0 = 1'b1; bus.wr_addr_0 = 5'd6; bus.wr_data_0 = 32'h22;
    bus.rd_addr_b = 5'd2;
    rst = 1'b1;
    #1;
    chk("rst2_pend_cnt", 32'(bus.pend_cnt), 32'h0);
    chk("rst2_rd_r5", bus.rd_data_a, 32'h0);
    chk("rst2_busy_r2", 32'(bus.rd_busy_b), 32'h0);
    chk("rst2_dbg", 32'(bus.dbg_data), 32'h0);
    chk("rst2_claim_ok", 32'(bus.claim_ok), 32'h1);
    @(posedge clk);
    #1 chk("rst2_hold_cnt", 32'(bus.pend_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus.rd_addr_a = 5'd6;
    #1 chk("rst2_write_ignored", bus.rd_data_a, 32'h0);
    bus.wr_en_0 = 1'b1; bus.wr_data_0 = 32'h33;
    bus.claim_en = 1'b1; bus.claim_addr = 5'd4;
    @(posedge clk);
    #1 idle();
    #1;
    chk("post_rst_write", bus.rd_data_a, 32'h33);
    chk("post_rst_cnt", 32'(bus.pend_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
